// File: rtl/parking_time_countdown_if.sv
// Load/status bundle between the time incrementer, the countdown and the display driver.
// COUNTDOWN_PAUSE_EN adds the pause input to the bundle.
interface parking_time_countdown_if;
    logic        load;
    logic [15:0] load_value;
`ifdef COUNTDOWN_PAUSE_EN
    logic        pause;
`endif
    logic [15:0] time_left;
    logic        display_on;
    logic        expired;
    logic        low_time;
    logic        sec_tick;

    modport master (
        output load, load_value,
`ifdef COUNTDOWN_PAUSE_EN
        output pause,
`endif
        input  time_left, display_on, expired, low_time, sec_tick
    );

    modport slave (
        input  load, load_value,
`ifdef COUNTDOWN_PAUSE_EN
        input  pause,
`endif
        output time_left, display_on, expired, low_time, sec_tick
    );
endinterface

// File: rtl/parking_time_countdown.sv
// Parking-meter countdown: counts loaded seconds down once per second and drives display blinking.
// Optional feature macro: COUNTDOWN_PAUSE_EN (freezes countdown and blinking while bus.pause=1).
module parking_time_countdown #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter logic [15:0] MAX_TIME   = 16'd9999,
    parameter logic [15:0] LOW_THRESH = 16'd200
) (
    input  logic                     clk,
    input  logic                     rst,
    parking_time_countdown_if.slave  bus
);
    localparam int unsigned HALF       = CLK_HZ / 2;
    localparam int          PW         = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(HALF - 1);

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_LOW,
        ST_EXPIRED
    } state_e;

    function automatic logic [15:0] sat_load(input logic [15:0] v);
        return (v > MAX_TIME) ? MAX_TIME : v;
    endfunction

    function automatic state_e classify(input logic [15:0] t);
        if (t == 16'd0)
            return ST_EXPIRED;
        else if (t < LOW_THRESH)
            return ST_LOW;
        else
            return ST_NORMAL;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic          phase_q, phase_d;
    logic [15:0]   time_q, time_d;
    logic          disp_q, disp_d;
    logic          tick_q, tick_d;
    state_e        state_q, state_d;
    logic          wrap, dec, freeze;

    always_comb begin
        freeze = 1'b0;
`ifdef COUNTDOWN_PAUSE_EN
        freeze = bus.pause;
`endif
        wrap    = (presc_q == PRESC_LAST);
        dec     = wrap && phase_q && (time_q != 16'd0) && !freeze;
        presc_d = wrap ? '0 : presc_q + PW'(1);
        phase_d = phase_q ^ wrap;
        time_d  = dec ? time_q - 16'd1 : time_q;
        tick_d  = dec;
        if (freeze) begin
            presc_d = presc_q;
            phase_d = phase_q;
        end
        // A load overrides any coincident wrap or decrement and restarts the second.
        if (bus.load) begin
            time_d  = sat_load(bus.load_value);
            presc_d = '0;
            phase_d = 1'b0;
            tick_d  = 1'b0;
        end
        state_d = classify(time_d);

        // Entering a new meter state always starts with digits visible.
        if (bus.load || (state_d != state_q) || freeze) begin
            disp_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_EXPIRED: disp_d = wrap ? !disp_q : disp_q;
                ST_LOW:     disp_d = (wrap && phase_q) ? !disp_q : disp_q;
                default:    disp_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            phase_q <= 1'b0;
            time_q  <= 16'd0;
            disp_q  <= 1'b1;
            tick_q  <= 1'b0;
            state_q <= ST_EXPIRED;
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
            time_q  <= time_d;
            disp_q  <= disp_d;
            tick_q  <= tick_d;
            state_q <= state_d;
        end
    end

    assign bus.time_left  = time_q;
    assign bus.display_on = disp_q;
    assign bus.expired    = (state_q == ST_EXPIRED);
    assign bus.low_time   = (state_q == ST_LOW);
    assign bus.sec_tick   = tick_q;
endmodule

// File: tb/tb_parking_time_countdown.sv
// Self-checking bench for parking_time_countdown with a cycle-count based reference model.
module tb_parking_time_countdown;
    localparam int CLK_HZ = 10;
    localparam int HALF   = CLK_HZ / 2;
    localparam int MAXT   = 9999;
    localparam int LOWT   = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    parking_time_countdown_if bus();

    parking_time_countdown #(.CLK_HZ(CLK_HZ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef COUNTDOWN_PAUSE_EN
    initial bus.pause = 1'b0;
`endif

    // Reference model: seconds remaining, cycles since last load/reset, display, tick.
    int m_time = 0;
    int m_k    = 0;
    bit m_disp = 1'b1;
    bit m_tick = 1'b0;

    function automatic int m_state(input int t);
        if (t == 0) return 0;
        if (t < LOWT) return 1;
        return 2;
    endfunction

    task automatic model_edge();
        int old_s, new_s;
        bit half, full, dec;
        if (rst) begin
            m_time = 0; m_disp = 1'b1; m_tick = 1'b0; m_k = 0;
        end else if (bus.load) begin
            m_time = (int'(bus.load_value) > MAXT) ? MAXT : int'(bus.load_value);
            m_disp = 1'b1; m_tick = 1'b0; m_k = 0;
        end else begin
            m_k++;
            half  = (m_k % HALF) == 0;
            full  = (m_k % CLK_HZ) == 0;
            old_s = m_state(m_time);
            dec   = full && (m_time > 0);
            if (dec) m_time--;
            m_tick = dec;
            new_s  = m_state(m_time);
            if (new_s != old_s)           m_disp = 1'b1;
            else if (new_s == 0 && half)  m_disp = !m_disp;
            else if (new_s == 1 && full)  m_disp = !m_disp;
            else if (new_s == 2)          m_disp = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_load(input int v);
        bus.load = 1'b1;
        bus.load_value = 16'(v);
        tick();
        bus.load = 1'b0;
    endtask

    function automatic logic [19:0] obs();
        return {bus.time_left, bus.display_on, bus.expired, bus.low_time, bus.sec_tick};
    endfunction

    function automatic logic [19:0] expv();
        return {16'(m_time), m_disp, (m_time == 0), (m_time > 0 && m_time < LOWT), m_tick};
    endfunction

    task automatic test_reset();
        bus.load = 1'b0;
        bus.load_value = 16'd0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== 20'h0_000C) begin
                errors++;
                $display("FAIL reset_state: got %h want %h", obs(), 20'h0_000C);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_countdown();
        int pulses = 0;
        do_load(3);
        checks++;
        if (bus.time_left !== 16'd3) begin
            errors++;
            $display("FAIL load3_value: got %0d want 3", bus.time_left);
        end
        for (int i = 1; i <= 45; i++) begin
            tick();
            if (bus.sec_tick === 1'b1) pulses++;
            checks++;
            if (bus.sec_tick !== (i == 10 || i == 20 || i == 30) || obs() !== expv()) begin
                errors++;
                $display("FAIL countdown_cycle%0d: got %h want %h", i, obs(), expv());
            end
        end
        checks++;
        if (pulses != 3 || bus.time_left !== 16'd0) begin
            errors++;
            $display("FAIL countdown_total: got %0d pulses time %0d want 3 pulses time 0", pulses, bus.time_left);
        end
    endtask

    task automatic test_saturate();
        do_load(12000);
        for (int i = 0; i < 50; i++) begin
            checks++;
            if (bus.display_on !== 1'b1 || bus.low_time !== 1'b0 || bus.expired !== 1'b0 ||
                bus.time_left !== 16'(MAXT - i / 10) || obs() !== expv()) begin
                errors++;
                $display("FAIL saturate_cycle%0d: got %h want %h", i, obs(), expv());
            end
            tick();
        end
    endtask

    task automatic test_low_blink();
        do_load(150);
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (bus.display_on !== ((k / 10) % 2 == 0) || bus.low_time !== 1'b1 ||
                bus.time_left !== 16'(150 - k / 10) || obs() !== expv()) begin
                errors++;
                $display("FAIL low_blink_cycle%0d: got %h want %h", k, obs(), expv());
            end
            tick();
        end
    endtask

    task automatic test_expired_blink();
        do_load(2);
        for (int k = 1; k <= 20; k++) tick();
        for (int k = 20; k < 50; k++) begin
            checks++;
            if (bus.expired !== 1'b1 || bus.time_left !== 16'd0 ||
                bus.display_on !== (((k - 20) / 5) % 2 == 0) ||
                (k > 20 && bus.sec_tick !== 1'b0) || obs() !== expv()) begin
                errors++;
                $display("FAIL expired_blink_cycle%0d: got %h want %h", k, obs(), expv());
            end
            tick();
        end
    endtask

    task automatic test_load_on_wrap();
        do_load(60);
        for (int k = 1; k <= 9; k++) tick();
        do_load(50);
        for (int j = 0; j <= 10; j++) begin
            checks++;
            if (bus.time_left !== ((j == 10) ? 16'd49 : 16'd50) ||
                bus.sec_tick !== (j == 10) || obs() !== expv()) begin
                errors++;
                $display("FAIL load_on_wrap_cycle%0d: got %h want %h", j, obs(), expv());
            end
            tick();
        end
    endtask

    task automatic test_rst_mid();
        do_load(10);
        for (int k = 1; k <= 30; k++) tick();
        checks++;
        if (bus.time_left !== 16'd7) begin
            errors++;
            $display("FAIL rst_mid_pre: got %0d want 7", bus.time_left);
        end
        rst = 1'b1;
        bus.load = 1'b1;
        bus.load_value = 16'd99;
        tick();
        rst = 1'b0;
        bus.load = 1'b0;
        checks++;
        if (bus.time_left !== 16'd0 || bus.expired !== 1'b1 || bus.display_on !== 1'b1 ||
            bus.low_time !== 1'b0 || bus.sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_post: got %h want %h", obs(), 20'h0_000C);
        end
    endtask

    task automatic test_thresholds();
        int vals [6] = '{200, 199, 0, 1, 10000, 9999};
        foreach (vals[v]) begin
            do_load(vals[v]);
            for (int k = 0; k < 15; k++) begin
                checks++;
                if (obs() !== expv()) begin
                    errors++;
                    $display("FAIL threshold_%0d_cycle%0d: got %h want %h", vals[v], k, obs(), expv());
                end
                tick();
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            bus.load = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 3))
                0:       bus.load_value = 16'($urandom);
                1:       bus.load_value = 16'($urandom_range(0, 3));
                default: bus.load_value = 16'($urandom_range(0, 400));
            endcase
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h want %h", i, obs(), expv());
            end
        end
        rst = 1'b0;
        bus.load = 1'b0;
    endtask

    initial begin
        bus.load = 1'b0;
        bus.load_value = 16'd0;
        test_reset();
        test_countdown();
        test_saturate();
        test_low_blink();
        test_expired_blink();
        test_load_on_wrap();
        test_rst_mid();
        test_thresholds();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
